// File: rtl/alarm_pkg.sv
// Shared widths, channel state encoding and time helpers for the multi-alarm clock.
package alarm_pkg;

  localparam int HOURS_W  = 5;
  localparam int MIN_W    = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } alarm_state_t;

  typedef struct packed {
    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
  } hhmm_t;

  function automatic logic time_valid(input logic [HOURS_W-1:0] h,
                                      input logic [MIN_W-1:0]   m);
    return (h <= HOURS_W'(MAX_HOUR)) && (m <= MIN_W'(MAX_MIN));
  endfunction

  function automatic hhmm_t time_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.minutes == MIN_W'(MAX_MIN)) begin
      r.minutes = '0;
      r.hours   = (t.hours == HOURS_W'(MAX_HOUR)) ? '0 : t.hours + 1'b1;
    end else begin
      r.minutes = t.minutes + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm: stored time, arm/ring/snooze FSM with snooze countdown and ring timeout.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  minute_tick,
  input  hhmm_t cur_time,
  input  logic  wr,
  input  hhmm_t wr_time,
  input  logic  wr_enable,
  input  logic  snooze,
  input  logic  dismiss,
  output logic  ringing,
  output logic  ring_next
);

  localparam int SNZ_W  = $clog2(SNOOZE_MIN + 1);
  localparam int RING_W = $clog2(RING_MIN + 1);

  alarm_state_t      state_reg, state_next;
  hhmm_t             alarm_time_reg, alarm_time_next;
  logic [SNZ_W-1:0]  snooze_cnt_reg, snooze_cnt_next;
  logic [RING_W-1:0] ring_cnt_reg, ring_cnt_next;
  logic              ringing_reg;

  always_comb begin
    state_next      = state_reg;
    alarm_time_next = alarm_time_reg;
    snooze_cnt_next = snooze_cnt_reg;
    ring_cnt_next   = ring_cnt_reg;
    if (wr) begin
      // A write overrides whatever the channel was doing, including acks.
      alarm_time_next = wr_time;
      state_next      = wr_enable ? ARMED : OFF;
      snooze_cnt_next = '0;
      ring_cnt_next   = '0;
    end else begin
      case (state_reg)
        ARMED: begin
          if (minute_tick && (cur_time == alarm_time_reg)) begin
            state_next    = RINGING;
            ring_cnt_next = '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_next = ARMED;
          end else if (snooze) begin
            state_next      = SNOOZED;
            snooze_cnt_next = SNZ_W'(SNOOZE_MIN);
          end else if (minute_tick) begin
            if (ring_cnt_reg == RING_W'(RING_MIN - 1)) begin
              state_next = ARMED;
            end else begin
              ring_cnt_next = ring_cnt_reg + 1'b1;
            end
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            state_next = ARMED;
          end else if (minute_tick) begin
            snooze_cnt_next = snooze_cnt_reg - 1'b1;
            if (snooze_cnt_reg == SNZ_W'(1)) begin
              state_next    = RINGING;
              ring_cnt_next = '0;
            end
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= OFF;
      alarm_time_reg <= '0;
      snooze_cnt_reg <= '0;
      ring_cnt_reg   <= '0;
      ringing_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      alarm_time_reg <= alarm_time_next;
      snooze_cnt_reg <= snooze_cnt_next;
      ring_cnt_reg   <= ring_cnt_next;
      ringing_reg    <= (state_next == RINGING);
    end
  end

  assign ringing   = ringing_reg;
  // Exposed so the top can register any_ring in the same cycle as ringing.
  assign ring_next = (state_next == RINGING);

endmodule

// File: rtl/alarm_clock_multi.sv
// 24-hour hh:mm clock with a cycle prescaler and N independent alarm channels.
module alarm_clock_multi
  import alarm_pkg::*;
#(
  parameter  int TICKS_PER_MIN = 600000000,
  parameter  int N_ALARMS      = 4,
  parameter  int SNOOZE_MIN    = 5,
  parameter  int RING_MIN      = 2,
  localparam int IDX_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_time,
  input  logic [HOURS_W-1:0]  set_hours,
  input  logic [MIN_W-1:0]    set_minutes,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [HOURS_W-1:0]  wr_hours,
  input  logic [MIN_W-1:0]    wr_minutes,
  input  logic                wr_enable,
  input  logic [IDX_W-1:0]    ack_idx,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [HOURS_W-1:0]  cur_hours,
  output logic [MIN_W-1:0]    cur_minutes,
  output logic                minute_tick,
  output logic [N_ALARMS-1:0] ringing,
  output logic                any_ring
);

  localparam int PRESC_W = $clog2(TICKS_PER_MIN);

  logic [PRESC_W-1:0]  presc_reg;
  hhmm_t               time_reg;
  logic                minute_tick_reg;
  logic                any_ring_reg;
  logic [N_ALARMS-1:0] ring_next;
  logic                terminal;
  logic                load_ok;
  logic                wr_ok;
  hhmm_t               wr_time;

  assign terminal = (presc_reg == PRESC_W'(TICKS_PER_MIN - 1));
  assign load_ok  = set_time && time_valid(set_hours, set_minutes);
  assign wr_ok    = wr_en && time_valid(wr_hours, wr_minutes);
  assign wr_time  = '{hours: wr_hours, minutes: wr_minutes};

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg       <= '0;
      time_reg        <= '0;
      minute_tick_reg <= 1'b0;
    end else if (load_ok) begin
      presc_reg       <= '0;
      time_reg        <= '{hours: set_hours, minutes: set_minutes};
      minute_tick_reg <= 1'b0;
    end else if (terminal) begin
      presc_reg       <= '0;
      time_reg        <= time_inc(time_reg);
      minute_tick_reg <= 1'b1;
    end else begin
      presc_reg       <= presc_reg + 1'b1;
      minute_tick_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_ring_reg <= 1'b0;
    end else begin
      any_ring_reg <= |ring_next;
    end
  end

  // Indices with no matching channel simply select nothing.
  generate
    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
      alarm_channel #(
        .SNOOZE_MIN(SNOOZE_MIN),
        .RING_MIN  (RING_MIN)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .minute_tick(minute_tick_reg),
        .cur_time   (time_reg),
        .wr         (wr_ok && (wr_idx == IDX_W'(gi))),
        .wr_time    (wr_time),
        .wr_enable  (wr_enable),
        .snooze     (snooze && (ack_idx == IDX_W'(gi))),
        .dismiss    (dismiss && (ack_idx == IDX_W'(gi))),
        .ringing    (ringing[gi]),
        .ring_next  (ring_next[gi])
      );
    end
  endgenerate

  assign cur_hours   = time_reg.hours;
  assign cur_minutes = time_reg.minutes;
  assign minute_tick = minute_tick_reg;
  assign any_ring    = any_ring_reg;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi with 4-cycle minutes, 2 channels, 2-minute snooze and ring.
module tb_alarm_clock_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_time;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       wr_en;
  logic [0:0] wr_idx;
  logic [4:0] wr_hours;
  logic [5:0] wr_minutes;
  logic       wr_enable;
  logic [0:0] ack_idx;
  logic       snooze;
  logic       dismiss;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       minute_tick;
  logic [1:0] ringing;
  logic       any_ring;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_clock_multi #(
    .TICKS_PER_MIN(4),
    .N_ALARMS     (2),
    .SNOOZE_MIN   (2),
    .RING_MIN     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_time   (set_time),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_hours   (wr_hours),
    .wr_minutes (wr_minutes),
    .wr_enable  (wr_enable),
    .ack_idx    (ack_idx),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .minute_tick(minute_tick),
    .ringing    (ringing),
    .any_ring   (any_ring)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] hm(input int h, input int m);
    return 32'(h * 64 + m);
  endfunction

  function automatic logic [31:0] now();
    return 32'({cur_hours, cur_minutes});
  endfunction

  task automatic set_t(input int h, input int m);
    set_time = 1'b1; set_hours = 5'(h); set_minutes = 6'(m);
    step();
    set_time = 1'b0;
  endtask

  task automatic write_alarm(input int idx, input int h, input int m, input logic en);
    wr_en = 1'b1; wr_idx = 1'(idx); wr_hours = 5'(h); wr_minutes = 6'(m); wr_enable = en;
    step();
    wr_en = 1'b0;
  endtask

  task automatic ack(input int idx, input logic s, input logic d);
    ack_idx = 1'(idx); snooze = s; dismiss = d;
    step();
    snooze = 1'b0; dismiss = 1'b0;
  endtask

  initial begin
    int   tick_cnt;
    logic seen_ring;
    rst = 1'b1; set_time = 1'b0; set_hours = '0; set_minutes = '0;
    wr_en = 1'b0; wr_idx = '0; wr_hours = '0; wr_minutes = '0; wr_enable = 1'b0;
    ack_idx = '0; snooze = 1'b0; dismiss = 1'b0;

    // Reset values
    step();
    check("reset_time", now(), hm(0, 0));
    check("reset_tick", 32'(minute_tick), 0);
    check("reset_ringing", 32'(ringing), 0);
    check("reset_any", 32'(any_ring), 0);
    rst = 1'b0;

    // 1. Wrap 23:59 -> 00:00 with a single tick
    set_t(23, 59);
    check("load_2359", now(), hm(23, 59));
    tick_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      tick_cnt += 32'(minute_tick);
    end
    check("wrap_time", now(), hm(0, 0));
    check("wrap_tick_count", 32'(tick_cnt), 1);
    check("wrap_tick_now", 32'(minute_tick), 1);
    step();
    check("tick_one_cycle", 32'(minute_tick), 0);

    // 2. Match on channel 1, then ring timeout
    write_alarm(1, 7, 30, 1'b1);
    set_t(7, 29);
    steps(4);
    check("match_time", now(), hm(7, 30));
    check("match_ring_latency", 32'(ringing), 0);
    step();
    check("match_ring", 32'(ringing), 2);
    check("match_any", 32'(any_ring), 1);
    steps(7);
    check("ring_before_timeout", 32'(ringing), 2);
    step();
    check("ring_timeout", 32'(ringing), 0);
    check("any_timeout", 32'(any_ring), 0);

    // 3. Snooze, re-ring after two ticks, dismiss
    set_t(7, 29);
    steps(5);
    check("ring_again", 32'(ringing), 2);
    ack(1, 1'b1, 1'b0);
    check("snooze_drop", 32'(ringing), 0);
    check("snooze_any", 32'(any_ring), 0);
    steps(6);
    check("snoozing", 32'(ringing), 0);
    step();
    check("snooze_rering", 32'(ringing), 2);
    check("snooze_rering_time", now(), hm(7, 32));
    ack(1, 1'b0, 1'b1);
    check("dismiss_drop", 32'(ringing), 0);
    steps(4);
    check("no_ring_after_dismiss", 32'(ringing), 0);

    // 4. Two channels at 12:00; snooze+dismiss on channel 0 dismisses
    write_alarm(0, 12, 0, 1'b1);
    write_alarm(1, 12, 0, 1'b1);
    set_t(11, 59);
    steps(5);
    check("both_ring", 32'(ringing), 3);
    ack(0, 1'b1, 1'b1);
    check("dismiss_wins", 32'(ringing), 2);
    check("dismiss_wins_any", 32'(any_ring), 1);
    ack(1, 1'b0, 1'b1);
    check("both_off", 32'(ringing), 0);
    steps(6);
    check("ch0_not_snoozed", 32'(ringing), 0);

    // 5. Invalid time loads and alarm writes are ignored
    set_t(10, 10);
    check("load_1010", now(), hm(10, 10));
    write_alarm(0, 10, 12, 1'b1);
    write_alarm(0, 24, 12, 1'b0);
    set_t(24, 0);
    check("bad_hours", now(), hm(10, 10));
    set_t(12, 60);
    check("bad_min_prescaler_runs", now(), hm(10, 11));
    check("bad_min_tick", 32'(minute_tick), 1);
    steps(4);
    check("reach_1012", now(), hm(10, 12));
    step();
    check("bad_write_ignored", 32'(ringing), 1);

    // 6. Reset mid-snooze
    ack(0, 1'b1, 1'b0);
    check("snooze_ch0", 32'(ringing), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_time", now(), hm(0, 0));
    check("rst_ringing", 32'(ringing), 0);
    check("rst_any", 32'(any_ring), 0);
    check("rst_tick", 32'(minute_tick), 0);
    seen_ring = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_ring |= (|ringing) | any_ring;
    end
    check("no_ring_after_rst", 32'(seen_ring), 0);
    // Stored times are 00:00 after reset, but channels are OFF
    set_t(23, 59);
    steps(5);
    check("rst_wrap_time", now(), hm(0, 0));
    check("rst_channels_off", 32'(ringing), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
